cla_adder_64: RTL and testbench
===============================

Name: cla_adder_64

Overview:
- 64-bit unsigned carry-look-ahead adder with a registered output stage.
- Computes SUM = A + B (mod 2^64) and the carry-out CARRY.
- Datapath arithmetic primitive for the ALU/adder test area; sits between operand registers and any consumer that needs a full 64-bit sum plus carry in one cycle.
- Carry logic is hierarchical look-ahead (4-bit groups, then group-level look-ahead), with no ripple across groups.

Parameters:
- WIDTH, 64, operand/sum width; must be a multiple of GROUP. Only 64 is verified.
- GROUP, 4, bits per look-ahead group (generate/propagate block size).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- IN_VALID  input  1  operands on A/B are valid this cycle
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- SUM  output  WIDTH  registered A+B, low WIDTH bits
- CARRY  output  1  registered carry-out of bit WIDTH-1
- OUT_VALID  output  1  SUM/CARRY hold a result produced from a valid input

Behaviour:
- Reset: on a clk edge with rst=1, SUM=0, CARRY=0 and OUT_VALID=0. Reset has priority over IN_VALID, and a result in flight is discarded.
- Latency: exactly 1 cycle.
  - Inputs sampled at edge N.
  - SUM, CARRY and OUT_VALID update at edge N and are visible after it.
  - No internal pipelining beyond this register.
  - Throughput is one operation per cycle.
- IN_VALID=1: register {CARRY,SUM} <= A + B (+ cin, see option) and set OUT_VALID <= 1.
- IN_VALID=0: SUM/CARRY hold their previous value and OUT_VALID <= 0.
- Bit-level signals: g_i = A_i & B_i, p_i = A_i ^ B_i, sum_i = p_i ^ c_i.
- Group level: each 4-bit group produces its internal carries plus group G/P:
  - G = g3 | p3g2 | p3p2g1 | p3p2p1g0
  - P = p3p2p1p0
- Second level: 16 group G/P pairs are combined in 4-group super-blocks, then across the super-blocks, to form every group carry-in. c0 = cin (0 when the option is absent).
- CARRY = c64 (unsigned carry-out). No signed overflow output.
- Arithmetic is modulo 2^64, with no saturation.
- Boundary cases:
  - all-ones + 1 gives SUM=0, CARRY=1.
  - 0 + 0 gives SUM=0, CARRY=0.
  - all-ones + all-ones gives SUM=all-ones minus 1, CARRY=1.
- X/Z on A/B while IN_VALID=0 must not affect the outputs.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro CLA_CARRY_IN_EN.
- When defined: extra input port CIN (1 bit, unsigned carry-in), used as c0. Result = A + B + CIN.
- When undefined: no CIN port; c0 tied to 0. Result = A + B.
- Reset and latency are identical in both builds.

Decomposition:
- Package cla_pkg holds:
  - localparam CLA_WIDTH=64 and CLA_GROUP=4
  - derived CLA_NGROUPS=WIDTH/GROUP
  - typedef word_t (logic [63:0])
  - typedef gp_t (struct: g, p)
- Sub-module cla_group_4 (purely combinational):
  - inputs: a[3:0], b[3:0], cin
  - outputs: sum[3:0], group g, group p
  - instantiated 16 times
- The top level holds the two-level group-carry look-ahead and the output register.

Test Plan:
- Reset: hold rst=1 with IN_VALID=1, A=5, B=7 -> SUM=0, CARRY=0, OUT_VALID=0. Release rst -> next cycle SUM=12, OUT_VALID=1.
- Small exhaustive sweep: A=0..32 × B=0..32, IN_VALID=1 each cycle -> one cycle later SUM=A+B, CARRY=0, for all 1089 pairs.
- Carry ripple worst case: A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> SUM=0, CARRY=1. A=B=all-ones -> SUM=64'hFFFF_FFFF_FFFF_FFFE, CARRY=1.
- Group boundaries: A=64'h0000_0000_FFFF_FFFF, B=1 -> SUM=64'h0000_0001_0000_0000, CARRY=0. A=64'h8000_0000_0000_0000, B=64'h8000_0000_0000_0000 -> SUM=0, CARRY=1.
- Hold/valid: IN_VALID=1 with A=3, B=4, then IN_VALID=0 with A=100, B=200 -> SUM stays 7, OUT_VALID drops to 0.
- Random with CLA_CARRY_IN_EN: 10k random A, B, CIN -> {CARRY,SUM} equals the 65-bit A+B+CIN reference, at 1-cycle latency. The same run without the macro must match A+B.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and look-ahead helpers for the 64-bit carry-look-ahead adder.
package cla_pkg;

   localparam int unsigned CLA_WIDTH   = 64;
   localparam int unsigned CLA_GROUP   = 4;
   localparam int unsigned CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

   typedef logic [CLA_WIDTH-1:0] word_t;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // Carry-ins of four adjacent blocks, fully expanded so no block waits on its neighbour.
   function automatic logic [3:0] cla4_cin(input gp_t [3:0] gp, input logic cin);
      logic [3:0] c;
      c[0] = cin;
      c[1] = gp[0].g | (gp[0].p & cin);
      c[2] = gp[1].g | (gp[1].p & gp[0].g) | (gp[1].p & gp[0].p & cin);
      c[3] = gp[2].g | (gp[2].p & gp[1].g) | (gp[2].p & gp[1].p & gp[0].g)
           | (gp[2].p & gp[1].p & gp[0].p & cin);
      return c;
   endfunction

   // Merged generate/propagate of four adjacent blocks.
   function automatic gp_t gp4(input gp_t [3:0] gp);
      gp_t r;
      r.g = gp[3].g | (gp[3].p & gp[2].g) | (gp[3].p & gp[2].p & gp[1].g)
          | (gp[3].p & gp[2].p & gp[1].p & gp[0].g);
      r.p = gp[3].p & gp[2].p & gp[1].p & gp[0].p;
      return r;
   endfunction

endpackage

// File: rtl/cla_group_4.sv
// Combinational 4-bit look-ahead group: local sum plus group generate/propagate.
module cla_group_4
   import cla_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       g_o,
   output logic       p_o
);

   gp_t [3:0]  bit_gp;
   logic [3:0] bit_p;
   logic [3:0] carry;
   gp_t        grp;

   always_comb begin
      bit_gp = '0;
      bit_p  = '0;
      for (int i = 0; i < 4; i++) begin
         bit_gp[i].g = a_i[i] & b_i[i];
         bit_gp[i].p = a_i[i] ^ b_i[i];
         bit_p[i]    = a_i[i] ^ b_i[i];
      end
   end

   // Group G/P depend only on the operands, never on cin, keeping the look-ahead loop-free.
   assign grp   = gp4(bit_gp);
   assign g_o   = grp.g;
   assign p_o   = grp.p;
   assign carry = cla4_cin(bit_gp, cin_i);
   assign sum_o = bit_p ^ carry;

endmodule

// File: rtl/cla_adder_64.sv
// 64-bit two-level carry-look-ahead adder with a single output register stage.
// Build option CLA_CARRY_IN_EN adds a CIN port used as the carry into bit 0.
module cla_adder_64
   import cla_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_WIDTH,
   parameter int unsigned GROUP = CLA_GROUP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IN_VALID,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef CLA_CARRY_IN_EN
   input  logic             CIN,
`endif
   output logic [WIDTH-1:0] SUM,
   output logic             CARRY,
   output logic             OUT_VALID
);

   localparam int unsigned NGROUPS = WIDTH / GROUP;
   localparam int unsigned SUPER   = 4;
   localparam int unsigned NSUPER  = NGROUPS / SUPER;

   logic               c0;
   logic [NGROUPS-1:0] grp_g;
   logic [NGROUPS-1:0] grp_p;
   gp_t  [NGROUPS-1:0] grp_gp;
   gp_t  [NSUPER-1:0]  sup_gp;
   gp_t                all_gp;
   logic [NSUPER-1:0]  sup_c;
   logic [NGROUPS-1:0] grp_c;
   logic               carry_c;
   logic [WIDTH-1:0]   sum_c;

   logic [WIDTH-1:0]   sum_d,   sum_q;
   logic               carry_d, carry_q;
   logic               valid_d, valid_q;

`ifdef CLA_CARRY_IN_EN
   assign c0 = CIN;
`else
   assign c0 = 1'b0;
`endif

   for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
      cla_group_4 u_grp (
         .a_i   (A[gi*GROUP +: GROUP]),
         .b_i   (B[gi*GROUP +: GROUP]),
         .cin_i (grp_c[gi]),
         .sum_o (sum_c[gi*GROUP +: GROUP]),
         .g_o   (grp_g[gi]),
         .p_o   (grp_p[gi])
      );
   end

   // Second level: super-block G/P, super-block carry-ins, then every group carry-in.
   always_comb begin
      grp_gp = '0;
      sup_gp = '0;
      grp_c  = '0;
      for (int i = 0; i < int'(NGROUPS); i++) begin
         grp_gp[i].g = grp_g[i];
         grp_gp[i].p = grp_p[i];
      end
      for (int s = 0; s < int'(NSUPER); s++) begin
         sup_gp[s] = gp4(grp_gp[s*SUPER +: SUPER]);
      end
      sup_c   = cla4_cin(sup_gp, c0);
      for (int s = 0; s < int'(NSUPER); s++) begin
         grp_c[s*SUPER +: SUPER] = cla4_cin(grp_gp[s*SUPER +: SUPER], sup_c[s]);
      end
      all_gp  = gp4(sup_gp);
      carry_c = all_gp.g | (all_gp.p & c0);
   end

   // Result is captured only for valid operands; otherwise the last result is held.
   always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      valid_d = IN_VALID;
      if (IN_VALID) begin
         sum_d   = sum_c;
         carry_d = carry_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
      end
   end

   assign SUM       = sum_q;
   assign CARRY     = carry_q;
   assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_cla_adder_64.sv
// Directed and random checks of cla_adder_64; honours CLA_CARRY_IN_EN when defined.
module tb_cla_adder_64;
   import cla_pkg::*;

   logic  clk;
   logic  rst;
   logic  in_valid;
   word_t a;
   word_t b;
   logic  cin;
   word_t sum;
   logic  carry;
   logic  out_valid;

   int n_tests;
   int n_fail;

   cla_adder_64 dut (
      .clk       (clk),
      .rst       (rst),
      .IN_VALID  (in_valid),
      .A         (a),
      .B         (b),
`ifdef CLA_CARRY_IN_EN
      .CIN       (cin),
`endif
      .SUM       (sum),
      .CARRY     (carry),
      .OUT_VALID (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, then sample 1 time unit after the next rising edge.
   task automatic apply(input word_t av, input word_t bv, input logic cv, input logic vv);
      @(negedge clk);
      a        = av;
      b        = bv;
      cin      = cv;
      in_valid = vv;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      apply(64'd5, 64'd7, 1'b0, 1'b1);
      apply(64'd5, 64'd7, 1'b0, 1'b1);
      n_tests++;
      if (sum !== 64'd0 || carry !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got sum=%h carry=%b valid=%b, expected sum=0 carry=0 valid=0",
                  sum, carry, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (sum !== 64'd12 || carry !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: got sum=%h carry=%b valid=%b, expected sum=c carry=0 valid=1",
                  sum, carry, out_valid);
      end
   endtask

   task automatic test_sweep;
      word_t exp_s;
      for (int i = 0; i <= 32; i++) begin
         for (int j = 0; j <= 32; j++) begin
            apply(64'(i), 64'(j), 1'b0, 1'b1);
            exp_s = 64'(i + j);
            n_tests++;
            if (sum !== exp_s || carry !== 1'b0 || out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL sweep %0d+%0d: got sum=%h carry=%b valid=%b, expected sum=%h carry=0 valid=1",
                        i, j, sum, carry, out_valid, exp_s);
            end
         end
      end
   endtask

   task automatic test_boundaries;
      word_t va [6];
      word_t vb [6];
      word_t es [6];
      logic  ec [6];
      va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd1;
      es[0] = 64'd0;                   ec[0] = 1'b1;
      va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      es[1] = 64'hFFFF_FFFF_FFFF_FFFE; ec[1] = 1'b1;
      va[2] = 64'h0000_0000_FFFF_FFFF; vb[2] = 64'd1;
      es[2] = 64'h0000_0001_0000_0000; ec[2] = 1'b0;
      va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000;
      es[3] = 64'd0;                   ec[3] = 1'b1;
      va[4] = 64'd0;                   vb[4] = 64'd0;
      es[4] = 64'd0;                   ec[4] = 1'b0;
      va[5] = 64'h0000_FFFF_0000_FFFF; vb[5] = 64'h0000_0001_0000_0001;
      es[5] = 64'h0001_0000_0001_0000; ec[5] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         apply(va[k], vb[k], 1'b0, 1'b1);
         n_tests++;
         if (sum !== es[k] || carry !== ec[k] || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary%0d: got sum=%h carry=%b valid=%b, expected sum=%h carry=%b valid=1",
                     k, sum, carry, out_valid, es[k], ec[k]);
         end
      end
   endtask

   task automatic test_hold;
      apply(64'd3, 64'd4, 1'b0, 1'b1);
      n_tests++;
      if (sum !== 64'd7 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_load: got sum=%h valid=%b, expected sum=7 valid=1", sum, out_valid);
      end
      apply(64'd100, 64'd200, 1'b0, 1'b0);
      n_tests++;
      if (sum !== 64'd7 || carry !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_idle: got sum=%h carry=%b valid=%b, expected sum=7 carry=0 valid=0",
                  sum, carry, out_valid);
      end
      apply('x, 'x, 1'bx, 1'b0);
      n_tests++;
      if (sum !== 64'd7 || carry !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_x: got sum=%h carry=%b valid=%b, expected sum=7 carry=0 valid=0",
                  sum, carry, out_valid);
      end
   endtask

   task automatic test_random;
      word_t     ra;
      word_t     rb;
      logic      rc;
      logic [64:0] ref_v;
      for (int n = 0; n < 10000; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
`ifdef CLA_CARRY_IN_EN
         rc = 1'($urandom_range(1, 0));
`else
         rc = 1'b0;
`endif
         apply(ra, rb, rc, 1'b1);
         ref_v = {1'b0, ra} + {1'b0, rb} + 65'(rc);
         n_tests++;
         if ({carry, sum} !== ref_v || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL random%0d %h+%h+%b: got carry=%b sum=%h valid=%b, expected carry=%b sum=%h",
                     n, ra, rb, rc, carry, sum, out_valid, ref_v[64], ref_v[63:0]);
         end
      end
   endtask

`ifdef CLA_CARRY_IN_EN
   task automatic test_carry_in;
      apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
      n_tests++;
      if (sum !== 64'd0 || carry !== 1'b1) begin
         n_fail++;
         $display("FAIL cin_wrap: got sum=%h carry=%b, expected sum=0 carry=1", sum, carry);
      end
   endtask
`endif

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      test_reset();
      test_sweep();
      test_boundaries();
      test_hold();
`ifdef CLA_CARRY_IN_EN
      test_carry_in();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
